// File: rtl/period_detector.sv
// period_detector: measures the period of a slow square wave in system-clock
// cycles and recovers the period code (n * BASE_CYC, n = 1..MAX_CODE) that
// produced it. It also reports loss of signal after TIMEOUT quiet cycles.
//
// Optional build macro: PERIOD_DETECTOR_GLITCH_FILTER_EN
//   When defined, a 4-sample deglitcher follows the synchroniser. Pulses and
//   dropouts shorter than 4 cycles are then ignored. Rise latency goes from
//   3 to 7 cycles. The latency is constant, so measured periods stay exact.
module period_detector #(
  parameter int BASE_CYC = 5000,
  parameter int MAX_CODE = 4,
  parameter int TOL      = 64,
  parameter int TIMEOUT  = 25000,
  parameter int STABLE_N = 2,
  parameter int CNT_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             new_meas,
  output logic [3:0]       period_code,
  output logic             code_valid,
  output logic             sig_lost
);

  localparam int                STAB_W   = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } class_t;

  // Returns the code whose nominal period lies within TOL of the measurement.
  // The tolerance bands are disjoint, so at most one code can hit.
  function automatic class_t classify(input logic [CNT_W-1:0] meas);
    class_t res;
    int     diff;
    res = '0;
    for (int n = 1; n <= MAX_CODE; n++) begin
      diff = int'(meas) - n * BASE_CYC;
      if (diff >= -TOL && diff <= TOL) begin
        res.hit  = 1'b1;
        res.code = 4'(n);
      end
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Input path: synchroniser, optional deglitcher, rising-edge detect
  // --------------------------------------------------------------------------
  logic sync_q0;
  logic sync_q1;
  logic level;
  logic level_d;
  logic rise;

  // Two-flop synchroniser for the asynchronous input.
  // NOTE: non-blocking assignments in clocked blocks, so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
    end else begin
      sync_q0 <= sig_in;
      sync_q1 <= sync_q0;
    end
  end

`ifdef PERIOD_DETECTOR_GLITCH_FILTER_EN
  logic [1:0] agree_cnt;
  logic       filt_level;

  // The filtered level flips only after 4 consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      agree_cnt  <= 2'd0;
      filt_level <= 1'b0;
    end else if (sync_q1 == filt_level) begin
      agree_cnt <= 2'd0;
    end else if (agree_cnt == 2'd3) begin
      filt_level <= sync_q1;
      agree_cnt  <= 2'd0;
    end else begin
      agree_cnt <= agree_cnt + 2'd1;
    end
  end

  assign level = filt_level;
`else
  assign level = sync_q1;
`endif

  // Delay flop for the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

  // --------------------------------------------------------------------------
  // Measurement FSM and code stability tracking
  // --------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  meas_d;
  logic              new_d;
  logic              lost_d;
  logic [3:0]        cand_q;
  logic [3:0]        cand_d;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;
  logic [3:0]        code_d;
  logic              meas_done;
  class_t            cls;

  // State and datapath registers. Reset clears everything, including any partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      meas_cnt    <= '0;
      new_meas    <= 1'b0;
      sig_lost    <= 1'b0;
      cand_q      <= '0;
      stab_q      <= '0;
      period_code <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      meas_cnt    <= meas_d;
      new_meas    <= new_d;
      sig_lost    <= lost_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      period_code <= code_d;
    end
  end

  // Next-state logic: counting, measurement capture, timeout and stability.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_d    = meas_cnt;
    new_d     = 1'b0;
    lost_d    = sig_lost;
    cand_d    = cand_q;
    stab_d    = stab_q;
    code_d    = period_code;
    meas_done = 1'b0;
    cls       = classify(cnt_q);

    case (state_q)
      IDLE: begin
        // The first edge only opens the measurement window.
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A rise in the same cycle the count hits TIMEOUT is still a measurement.
        if (rise) begin
          meas_d    = cnt_q;
          new_d     = 1'b1;
          cnt_d     = CNT_ONE;
          meas_done = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOST;
          lost_d  = 1'b1;
          stab_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOST: begin
        // The edge that ends a loss has no valid start reference.
        if (rise) begin
          cnt_d   = CNT_ONE;
          lost_d  = 1'b0;
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (meas_done) begin
      if (!cls.hit) begin
        stab_d = '0;
      end else if (cls.code == cand_q) begin
        stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_ONE;
      end else begin
        cand_d = cls.code;
        stab_d = STAB_ONE;
      end
    end

    // The reported code changes only when the candidate becomes stable.
    if (stab_d == STAB_MAX && stab_q != STAB_MAX) begin
      code_d = cand_d;
    end
  end

  assign code_valid = (stab_q == STAB_MAX);

endmodule
